misr_sig_checker: RTL and testbench

Parametrised multi-channel MISR with built-in signature check. It compacts NUM_CH parallel result words into one NUM_BITS signature over a programmed number of valid beats. At the end it compares the signature with a golden value and reports pass/fail. It sits at the systolic array output boundary for BIST. It supersedes the single-channel, fixed-54-bit MISR by adding selectable width, channel folding, a beat counter, an FSM and a golden compare.

---
 rtl/misr_sig_checker.sv | 149 ++++++++++++++
 tb/tb_misr_sig_checker.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_sig_checker.sv
// Multi-channel MISR with selectable width, channel folding, beat counter and golden compare.
// Optional `MISR_CH_MASK_EN adds i_mask to zero individual channels out of the fold.
module misr_sig_checker #(
    parameter int NUM_BITS = 54,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [NUM_BITS-1:0]        i_seed,
    input  logic [CNT_W-1:0]           i_len,
    input  logic [NUM_BITS-1:0]        i_golden,
    input  logic                       i_vld,
`ifdef MISR_CH_MASK_EN
    input  logic [NUM_CH-1:0]          i_mask,
`endif
    input  logic [NUM_CH*NUM_BITS-1:0] i_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_pass,
    output logic [NUM_BITS-1:0]        o_sig,
    output logic [CNT_W-1:0]           o_cnt
);

    localparam int unsigned NB    = NUM_BITS;
    localparam int unsigned NB_CH = NUM_CH;

    if (!(NUM_BITS == 8 || NUM_BITS == 16 || NUM_BITS == 32 || NUM_BITS == 54 || NUM_BITS == 64)) begin : g_bad_width
        $error("misr_sig_checker: NUM_BITS must be 8, 16, 32, 54 or 64");
    end
    if (NUM_CH < 1 || NUM_CH > NUM_BITS) begin : g_bad_ch
        $error("misr_sig_checker: NUM_CH must be in 1..NUM_BITS");
    end

    // A four-tap XNOR chain equals the inverted parity of the tap bits, so taps become a mask.
    function automatic logic [63:0] tap_mask(input int n);
        case (n)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_D008;
            32:      return 64'h0000_0000_8020_0003;
            54:      return 64'h0030_0000_0003_0000;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h0;
        endcase
    endfunction

    localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [NUM_BITS-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pass_q, pass_d;
    logic                  zlen_q, zlen_d;

    logic [NUM_BITS-1:0]   word;
    logic [NUM_BITS-1:0]   ch;
    logic [2*NUM_BITS-1:0] dbl;
    logic                  fb;
    logic [NUM_BITS-1:0]   next_sig;
`ifdef MISR_CH_MASK_EN
    logic [NUM_CH-1:0]     ch_mask;
`endif

    always_comb begin
        word = '0;
        ch   = '0;
        dbl  = '0;
`ifdef MISR_CH_MASK_EN
        ch_mask = '0;
`endif
        for (int unsigned k = 0; k < NB_CH; k++) begin
            ch = NUM_BITS'(i_data >> (k * NB));
`ifdef MISR_CH_MASK_EN
            ch_mask = i_mask >> k;
            if (ch_mask[0]) ch = '0;
`endif
            dbl  = {ch, ch} << (k % NB);
            word = word ^ NUM_BITS'(dbl >> NB);
        end
    end

    assign fb       = ~(^(sig_q & TAPS));
    assign next_sig = {sig_q[NUM_BITS-2:0], fb} ^ word;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        zlen_d  = zlen_q;
        if (i_start) begin
            sig_d  = i_seed;
            pass_d = 1'b0;
            if (i_len != '0) begin
                cnt_d   = i_len;
                zlen_d  = 1'b0;
                state_d = RUN;
            end else begin
                zlen_d  = 1'b1;
                state_d = DONE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (i_vld) begin
                        sig_d = next_sig;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            pass_d  = (next_sig == i_golden);
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (zlen_q) pass_d = (sig_q == i_golden);
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            zlen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            zlen_q  <= zlen_d;
        end
    end

    // A zero-length run compares live against i_golden while in DONE.
    assign o_pass = (state_q == DONE && zlen_q) ? (sig_q == i_golden) : pass_q;
    assign o_busy = (state_q == RUN);
    assign o_done = (state_q == DONE);
    assign o_sig  = sig_q;
    assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_misr_sig_checker.sv
// Self-checking bench for misr_sig_checker: an 8-bit/2-channel and a 54-bit/4-channel instance
// checked against a tap-list reference model.
module tb_misr_sig_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         a_start, a_vld;
    logic [7:0]   a_seed, a_golden;
    logic [15:0]  a_len, a_data;
    logic [1:0]   a_mask;
    logic         a_busy, a_done, a_pass;
    logic [7:0]   a_sig;
    logic [15:0]  a_cnt;

    logic         b_start, b_vld;
    logic [53:0]  b_seed, b_golden;
    logic [15:0]  b_len;
    logic [215:0] b_data;
    logic [3:0]   b_mask;
    logic         b_busy, b_done, b_pass;
    logic [53:0]  b_sig;
    logic [15:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    misr_sig_checker #(.NUM_BITS(8), .NUM_CH(2), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_seed(a_seed), .i_len(a_len),
        .i_golden(a_golden), .i_vld(a_vld),
`ifdef MISR_CH_MASK_EN
        .i_mask(a_mask),
`endif
        .i_data(a_data), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
        .o_sig(a_sig), .o_cnt(a_cnt)
    );

    misr_sig_checker #(.NUM_BITS(54), .NUM_CH(4), .CNT_W(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_seed(b_seed), .i_len(b_len),
        .i_golden(b_golden), .i_vld(b_vld),
`ifdef MISR_CH_MASK_EN
        .i_mask(b_mask),
`endif
        .i_data(b_data), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
        .o_sig(b_sig), .o_cnt(b_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] wmask(input int n);
        if (n == 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [63:0] m_fold(input logic [255:0] d, input int n, input int nch,
                                           input logic [7:0] msk);
        logic [63:0] w, x, mk;
        int r;
        w  = '0;
        mk = wmask(n);
        for (int k = 0; k < nch; k++) begin
            x = 64'(d >> (k * n)) & mk;
            r = k % n;
            if (r != 0) x = ((x << r) | (x >> (n - r))) & mk;
            if (!msk[k]) w = w ^ x;
        end
        return w;
    endfunction

    function automatic logic [63:0] m_step(input logic [63:0] s, input logic [63:0] w, input int n);
        int  t[4];
        bit  x;
        case (n)
            8:       t = '{8, 6, 5, 4};
            16:      t = '{16, 15, 13, 4};
            32:      t = '{32, 22, 2, 1};
            54:      t = '{54, 53, 18, 17};
            default: t = '{64, 63, 61, 60};
        endcase
        x = ~(s[t[0]-1] ^ s[t[1]-1]);
        x = ~(x ^ s[t[2]-1]);
        x = ~(x ^ s[t[3]-1]);
        return (((s << 1) | 64'(x)) & wmask(n)) ^ w;
    endfunction

    function automatic logic [7:0] eff_mask_b();
`ifdef MISR_CH_MASK_EN
        return 8'(b_mask);
`else
        return 8'h0;
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_start_run(input logic [7:0] seed, input logic [15:0] len);
        a_seed  = seed;
        a_len   = len;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_start = 0; a_vld = 0; a_seed = 0; a_len = 0; a_golden = 0; a_data = 0; a_mask = 0;
        b_start = 0; b_vld = 0; b_seed = 0; b_len = 0; b_golden = 0; b_data = 0; b_mask = 0;
        repeat (2) tick();
        checks++;
        if ({a_busy, a_done, a_pass, a_sig, a_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=0", {a_busy, a_done, a_pass, a_sig, a_cnt});
        end
        checks++;
        if ({b_busy, b_done, b_pass, b_sig, b_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=0", {b_busy, b_done, b_pass, b_sig, b_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_data();
        logic [7:0] exp_sig[3];
        logic [7:0] g;
        exp_sig = '{8'h01, 8'h03, 8'h07};
        for (int r = 0; r < 2; r++) begin
            g = (r == 0) ? 8'h07 : 8'h06;
            a_start_run(8'h00, 16'd3);
            checks++;
            if (a_busy !== 1'b1 || a_cnt !== 16'd3 || a_sig !== 8'h00) begin
                errors++;
                $display("FAIL zero_start got busy=%b cnt=%0d sig=%h exp 1 3 00", a_busy, a_cnt, a_sig);
            end
            for (int i = 0; i < 3; i++) begin
                a_data = 16'h0; a_vld = 1'b1; a_golden = g;
                tick();
                a_vld = 1'b0;
                checks++;
                if (a_sig !== exp_sig[i]) begin
                    errors++;
                    $display("FAIL zero_sig beat %0d got=%h exp=%h", i, a_sig, exp_sig[i]);
                end
                checks++;
                if (i < 2 && (a_done !== 1'b0 || a_busy !== 1'b1)) begin
                    errors++;
                    $display("FAIL zero_mid got done=%b busy=%b exp 0 1", a_done, a_busy);
                end else if (i == 2 && (a_done !== 1'b1 || a_busy !== 1'b0 || a_pass !== (g == 8'h07))) begin
                    errors++;
                    $display("FAIL zero_done got done=%b busy=%b pass=%b exp 1 0 %b",
                             a_done, a_busy, a_pass, (g == 8'h07));
                end
            end
            tick();
            checks++;
            if (a_done !== 1'b0 || a_pass !== (g == 8'h07) || a_sig !== 8'h07 || a_cnt !== 16'd0) begin
                errors++;
                $display("FAIL zero_hold got done=%b pass=%b sig=%h cnt=%0d exp 0 %b 07 0",
                         a_done, a_pass, a_sig, a_cnt, (g == 8'h07));
            end
        end
    endtask

    task automatic test_fold();
        a_start_run(8'h00, 16'd1);
        a_data = 16'h0101; a_vld = 1'b1; a_golden = 8'h02;
        tick();
        a_vld = 1'b0;
        checks++;
        if (a_sig !== 8'h02 || a_done !== 1'b1 || a_pass !== 1'b1) begin
            errors++;
            $display("FAIL fold got sig=%h done=%b pass=%b exp 02 1 1", a_sig, a_done, a_pass);
        end
        tick();
    endtask

    task automatic test_lockup();
        a_start_run(8'hFF, 16'd4);
        for (int i = 0; i < 4; i++) begin
            a_data = 16'h0; a_vld = 1'b1; a_golden = 8'hFF;
            tick();
            a_vld = 1'b0;
            checks++;
            if (a_sig !== 8'hFF) begin
                errors++;
                $display("FAIL lockup beat %0d got=%h exp=ff", i, a_sig);
            end
        end
        checks++;
        if (a_done !== 1'b1 || a_pass !== 1'b1) begin
            errors++;
            $display("FAIL lockup_pass got done=%b pass=%b exp 1 1", a_done, a_pass);
        end
        tick();
    endtask

    task automatic test_len_zero();
        logic [7:0] seed, g, g2;
        for (int r = 0; r < 3; r++) begin
            seed = 8'($urandom);
            g    = (r == 0) ? seed : seed ^ 8'($urandom_range(1, 255));
            a_golden = g;
            a_start_run(seed, 16'd0);
            checks++;
            if (a_done !== 1'b1 || a_busy !== 1'b0 || a_sig !== seed || a_pass !== (seed == g)) begin
                errors++;
                $display("FAIL len0 got done=%b busy=%b sig=%h pass=%b exp 1 0 %h %b",
                         a_done, a_busy, a_sig, a_pass, seed, (seed == g));
            end
            g2 = (r == 1) ? seed : ~seed;
            a_golden = g2;
            #1;
            checks++;
            if (a_pass !== (seed == g2)) begin
                errors++;
                $display("FAIL len0_live got pass=%b exp %b", a_pass, (seed == g2));
            end
            tick();
            checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0 || a_pass !== (seed == g2)) begin
                errors++;
                $display("FAIL len0_after got done=%b busy=%b pass=%b exp 0 0 %b",
                         a_done, a_busy, a_pass, (seed == g2));
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] s2;
        a_start_run(8'($urandom), 16'd5);
        for (int i = 0; i < 2; i++) begin
            a_data = 16'($urandom); a_vld = 1'b1;
            tick();
        end
        // restart while a beat is also presented: beat must be dropped
        a_seed = 8'h00; a_len = 16'd1; a_start = 1'b1; a_vld = 1'b1; a_data = 16'hA5C3;
        tick();
        a_start = 1'b0; a_vld = 1'b0;
        checks++;
        if (a_sig !== 8'h00 || a_cnt !== 16'd1 || a_busy !== 1'b1 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL restart got sig=%h cnt=%0d busy=%b done=%b exp 00 1 1 0",
                     a_sig, a_cnt, a_busy, a_done);
        end
        a_data = 16'h0; a_vld = 1'b1; a_golden = 8'h01;
        tick();
        a_vld = 1'b0;
        checks++;
        if (a_sig !== 8'h01 || a_done !== 1'b1 || a_pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got sig=%h done=%b pass=%b exp 01 1 1", a_sig, a_done, a_pass);
        end
        // restart from DONE clears pass and re-enters RUN
        s2 = 8'($urandom);
        a_seed = s2; a_len = 16'd2; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if (a_busy !== 1'b1 || a_done !== 1'b0 || a_pass !== 1'b0 || a_sig !== s2 || a_cnt !== 16'd2) begin
            errors++;
            $display("FAIL restart_from_done got busy=%b done=%b pass=%b sig=%h cnt=%0d exp 1 0 0 %h 2",
                     a_busy, a_done, a_pass, a_sig, a_cnt, s2);
        end
        // finish this run with stalls interleaved
        a_vld = 1'b0; tick();
        a_vld = 1'b1; a_data = 16'h0; tick();
        a_vld = 1'b1; tick();
        a_vld = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL restart_tail got done=%b cnt=%0d exp 1 0", a_done, a_cnt);
        end
        tick();
    endtask

    task automatic test_idle_vld();
        logic [7:0]  s;
        logic [15:0] c;
        s = a_sig;
        c = a_cnt;
        for (int i = 0; i < 3; i++) begin
            a_vld = 1'b1; a_data = 16'($urandom);
            tick();
            checks++;
            if (a_sig !== s || a_cnt !== c || a_busy !== 1'b0 || a_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_vld got sig=%h cnt=%0d busy=%b done=%b exp %h %0d 0 0",
                         a_sig, a_cnt, a_busy, a_done, s, c);
            end
        end
        a_vld = 1'b0;
    endtask

    task automatic test_async_reset();
        a_start_run(8'($urandom), 16'd5);
        a_vld = 1'b1; a_data = 16'($urandom);
        b_seed = 54'($urandom); b_len = 16'd3; b_start = 1'b1;
        tick();
        a_vld = 1'b0; b_start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_busy, a_done, a_pass, a_sig, a_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset_a got=%h exp=0", {a_busy, a_done, a_pass, a_sig, a_cnt});
        end
        checks++;
        if ({b_busy, b_done, b_pass, b_sig, b_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset_b got=%h exp=0", {b_busy, b_done, b_pass, b_sig, b_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic run_rand_a(input int unsigned len, input bit match);
        logic [63:0] m;
        logic [7:0]  seed;
        logic [15:0] d;
        seed = 8'($urandom);
        a_start_run(seed, 16'(len));
        m = 64'(seed);
        checks++;
        if (a_sig !== seed || a_busy !== 1'b1 || a_cnt !== 16'(len)) begin
            errors++;
            $display("FAIL rand_a_start got sig=%h busy=%b cnt=%0d exp %h 1 %0d", a_sig, a_busy, a_cnt, seed, len);
        end
        for (int unsigned i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin
                a_vld = 1'b0; a_data = 16'($urandom);
                tick();
                checks++;
                if (a_sig !== m[7:0] || a_cnt !== 16'(len - i)) begin
                    errors++;
                    $display("FAIL rand_a_stall got sig=%h cnt=%0d exp %h %0d", a_sig, a_cnt, m[7:0], len - i);
                end
            end
            d = 16'($urandom);
            a_data = d; a_vld = 1'b1;
            m = m_step(m, m_fold(256'(d), 8, 2, 8'h0), 8);
            if (i == len - 1) a_golden = match ? m[7:0] : m[7:0] ^ (8'h1 << $urandom_range(0, 7));
            else              a_golden = 8'($urandom);
            tick();
            a_vld = 1'b0;
            checks++;
            if (a_sig !== m[7:0]) begin
                errors++;
                $display("FAIL rand_a_sig beat %0d got=%h exp=%h", i, a_sig, m[7:0]);
            end
            checks++;
            if (i == len - 1 && (a_done !== 1'b1 || a_busy !== 1'b0 || a_pass !== match)) begin
                errors++;
                $display("FAIL rand_a_done got done=%b busy=%b pass=%b exp 1 0 %b", a_done, a_busy, a_pass, match);
            end else if (i != len - 1 && (a_done !== 1'b0 || a_busy !== 1'b1 || a_cnt !== 16'(len - i - 1))) begin
                errors++;
                $display("FAIL rand_a_run got done=%b busy=%b cnt=%0d exp 0 1 %0d", a_done, a_busy, a_cnt, len - i - 1);
            end
        end
        tick();
        checks++;
        if (a_done !== 1'b0 || a_pass !== match || a_sig !== m[7:0]) begin
            errors++;
            $display("FAIL rand_a_hold got done=%b pass=%b sig=%h exp 0 %b %h", a_done, a_pass, a_sig, match, m[7:0]);
        end
    endtask

    task automatic run_rand_b(input int unsigned len, input bit match, input logic [3:0] msk);
        logic [63:0]  m;
        logic [53:0]  seed;
        logic [255:0] t;
        b_mask = msk;
        seed = {22'($urandom), 32'($urandom)};
        b_seed = seed; b_len = 16'(len); b_start = 1'b1;
        tick();
        b_start = 1'b0;
        m = 64'(seed);
        checks++;
        if (b_sig !== seed || b_busy !== 1'b1 || b_cnt !== 16'(len)) begin
            errors++;
            $display("FAIL rand_b_start got sig=%h busy=%b cnt=%0d exp %h 1 %0d", b_sig, b_busy, b_cnt, seed, len);
        end
        for (int unsigned i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                b_vld = 1'b0;
                tick();
            end
            for (int c = 0; c < 8; c++) t[c*32 +: 32] = $urandom;
            b_data = t[215:0]; b_vld = 1'b1;
            m = m_step(m, m_fold(256'(b_data), 54, 4, eff_mask_b()), 54);
            b_golden = match ? m[53:0] : m[53:0] ^ (54'h1 << $urandom_range(0, 53));
            tick();
            b_vld = 1'b0;
            checks++;
            if (b_sig !== m[53:0]) begin
                errors++;
                $display("FAIL rand_b_sig beat %0d got=%h exp=%h", i, b_sig, m[53:0]);
            end
        end
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_pass !== match || b_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rand_b_done got done=%b busy=%b pass=%b cnt=%0d exp 1 0 %b 0",
                     b_done, b_busy, b_pass, b_cnt, match);
        end
        tick();
    endtask

    task automatic test_random_a();
        for (int r = 0; r < 8; r++) run_rand_a(int'($urandom_range(1, 8)), r[0]);
    endtask

    task automatic test_random_b();
        run_rand_b(10, 1'b1, 4'hF);
        for (int r = 0; r < 6; r++) run_rand_b(int'($urandom_range(1, 12)), r[0], 4'($urandom));
    endtask

    initial begin
        test_reset();
        test_zero_data();
        test_fold();
        test_lockup();
        test_len_zero();
        test_restart();
        test_idle_vld();
        test_random_a();
        test_random_b();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
